// File: rtl/serial_frame_transmitter_pkg.sv
// Shared types and sizing for the serial frame transmitter.
// Holds the FSM state enum, the default length-field width and the bit-index width helper.
package serial_frame_transmitter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LEN,
        ST_XMIT,
        ST_DONE
    } state_e;

    localparam int CNT_W_DEF = 4;

    // Width of the LEN bit index: must hold 0..cnt_w.
    function automatic int idx_width(input int cnt_w);
        return $clog2(cnt_w + 1);
    endfunction

    localparam int IDX_W_DEF = idx_width(CNT_W_DEF);

endpackage

// File: rtl/serial_frame_transmitter_load_down_counter.sv
// W-bit down counter with synchronous active-low clear, parallel load and decrement.
// Ports: clk, clr_n (sync clear), load/load_val (load wins over dec), dec, count.
module load_down_counter
    import serial_frame_transmitter_pkg::*;
#(
    parameter int W = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/serial_frame_transmitter.sv
// Takes the serial line after a Start pulse: reads a CNT_W-bit length (MSB first), forwards that many payload bits.
// Ports: Clk, Rst (sync active-low), Start, SerIn -> SerOut, Valid, Busy, Done, Count (remaining bits).
module serial_frame_transmitter
    import serial_frame_transmitter_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic             SerIn,
    output logic             SerOut,
    output logic             Valid,
    output logic             Busy,
    output logic             Done,
    output logic [CNT_W-1:0] Count
);

    localparam int IDX_W = idx_width(CNT_W);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CNT_W - 1);

    state_e state_q;
    state_e state_d;

    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] len_d;
    logic [CNT_W-1:0] len_shift;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;
    logic             cnt_load;
    logic             cnt_dec;

    // Length register with the current line bit shifted in at the LSB.
    assign len_shift = CNT_W'({len_q, SerIn});

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        idx_d    = idx_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                len_d = '0;
                idx_d = '0;
                if (Start) begin
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                len_d = len_shift;
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == IDX_LAST) begin
                    // Last length bit: load the full field straight into Count.
                    cnt_load = 1'b1;
                    state_d  = (len_shift != '0) ? ST_XMIT : ST_DONE;
                end
            end
            ST_XMIT: begin
                cnt_dec = 1'b1;
                if (Count == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
        end
    end

    load_down_counter #(
        .W(CNT_W)
    ) u_count (
        .clk     (Clk),
        .clr_n   (Rst),
        .load    (cnt_load),
        .load_val(len_shift),
        .dec     (cnt_dec),
        .count   (Count)
    );

    assign Valid  = (state_q == ST_XMIT);
    assign SerOut = Valid & SerIn;
    assign Busy   = (state_q != ST_IDLE);
    assign Done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_serial_frame_transmitter.sv
// Self-checking bench for serial_frame_transmitter (CNT_W=4).
// A frame-timeline model predicts every output cycle; literal frame totals pin the model.
module tb_serial_frame_transmitter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         ser_in;
    logic         ser_out;
    logic         valid;
    logic         busy;
    logic         done;
    logic [W-1:0] count;

    always #5 clk = ~clk;

    serial_frame_transmitter #(
        .CNT_W(W)
    ) dut (
        .Clk   (clk),
        .Rst   (rst_n),
        .Start (start),
        .SerIn (ser_in),
        .SerOut(ser_out),
        .Valid (valid),
        .Busy  (busy),
        .Done  (done),
        .Count (count)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Frame timeline model: t0 = edge that accepted Start, lacc = length read so far.
    int e_cnt = 0;
    int t0    = -1;
    int lacc  = 0;
    bit armed = 1'b0;

    int          valid_n;
    int          busy_n;
    int          done_n;
    logic [63:0] cnt_seq;
    logic [31:0] ser_seq;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_edge();
        e_cnt++;
        if (!rst_n) begin
            t0    = -1;
            armed = 1'b1;
        end else if (t0 >= 0 && e_cnt - t0 >= 1 && e_cnt - t0 <= W) begin
            lacc = lacc * 2 + int'(ser_in);
        end else if (start && (t0 < 0 || e_cnt - t0 > W + lacc + 1)) begin
            t0   = e_cnt;
            lacc = 0;
        end
    endtask

    task automatic compare_cycle();
        int d;
        bit eb, ev, ed;
        int ec;
        if (!armed) return;
        eb = 1'b0;
        ev = 1'b0;
        ed = 1'b0;
        ec = 0;
        if (t0 >= 0) begin
            d  = e_cnt - t0 + 1;
            eb = (d >= 1) && (d <= W + lacc + 1);
            ev = (d > W) && (d <= W + lacc);
            ed = (d == W + lacc + 1);
            if (ev) ec = lacc - (d - W - 1);
        end
        chk("busy", 64'(busy), 64'(eb));
        chk("valid", 64'(valid), 64'(ev));
        chk("done", 64'(done), 64'(ed));
        chk("count", 64'(count), 64'(ec));
        chk("serout", 64'(ser_out), 64'(ev & ser_in));
    endtask

    task automatic clear_tally();
        valid_n = 0;
        busy_n  = 0;
        done_n  = 0;
        cnt_seq = '0;
        ser_seq = '0;
    endtask

    task automatic drive(input bit s, input bit d, input bit r);
        start  = s;
        ser_in = d;
        rst_n  = r;
        @(negedge clk);
        compare_cycle();
        if (busy) busy_n++;
        if (done) done_n++;
        if (valid) begin
            valid_n++;
            ser_seq = {ser_seq[30:0], ser_out};
            cnt_seq = {cnt_seq[59:0], count};
        end
        @(posedge clk);
        model_edge();
        #2;
    endtask

    task automatic send_len(input int l);
        logic [W-1:0] v;
        v = W'(l);
        for (int i = W - 1; i >= 0; i--) drive(1'b0, v[i], 1'b1);
    endtask

    task automatic send_payload(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) drive(1'b0, bits[i], 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        ser_in = 1'b0;
        clear_tally();
        @(posedge clk);
        #2;

        // Reset held with Start asserted
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_serout", 64'(ser_out), 64'd0);
        idle(3);
        chk("rst_stay_idle", 64'(busy), 64'd0);

        // Normal frame L=5, payload 10110
        clear_tally();
        drive(1'b1, 1'b0, 1'b1);
        send_len(5);
        send_payload(32'b10110, 5);
        idle(3);
        chk("norm_valid_n", 64'(valid_n), 64'd5);
        chk("norm_busy_n", 64'(busy_n), 64'd10);
        chk("norm_done_n", 64'(done_n), 64'd1);
        chk("norm_ser", 64'(ser_seq[4:0]), 64'b10110);
        chk("norm_cnt", 64'(cnt_seq[19:0]), 64'h54321);

        // Zero length
        clear_tally();
        drive(1'b1, 1'b0, 1'b1);
        send_len(0);
        idle(3);
        chk("zero_valid_n", 64'(valid_n), 64'd0);
        chk("zero_busy_n", 64'(busy_n), 64'd5);
        chk("zero_done_n", 64'(done_n), 64'd1);

        // Max length
        clear_tally();
        drive(1'b1, 1'b0, 1'b1);
        send_len(15);
        send_payload(32'h5A3C, 15);
        idle(3);
        chk("max_valid_n", 64'(valid_n), 64'd15);
        chk("max_busy_n", 64'(busy_n), 64'd20);
        chk("max_done_n", 64'(done_n), 64'd1);
        chk("max_ser", 64'(ser_seq[14:0]), 64'h5A3C);
        chk("max_cnt", cnt_seq[59:0], 64'h0FEDCBA987654321);

        // Start pulses during LEN, XMIT and the Done cycle
        clear_tally();
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b1);
        idle(4);
        chk("ign_valid_n", 64'(valid_n), 64'd5);
        chk("ign_busy_n", 64'(busy_n), 64'd10);
        chk("ign_done_n", 64'(done_n), 64'd1);
        chk("ign_ser", 64'(ser_seq[4:0]), 64'b10110);

        // Reset on the 3rd payload cycle of an L=5 frame
        clear_tally();
        drive(1'b1, 1'b0, 1'b1);
        send_len(5);
        drive(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b0);
        chk("abort_count", 64'(count), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        idle(2);
        chk("abort_done_n", 64'(done_n), 64'd0);
        chk("abort_valid_n", 64'(valid_n), 64'd3);
        chk("abort_busy_n", 64'(busy_n), 64'd7);

        // Clean frame after the abort, L=2
        clear_tally();
        drive(1'b1, 1'b0, 1'b1);
        send_len(2);
        send_payload(32'b11, 2);
        idle(3);
        chk("post_valid_n", 64'(valid_n), 64'd2);
        chk("post_busy_n", 64'(busy_n), 64'd7);
        chk("post_done_n", 64'(done_n), 64'd1);
        chk("post_cnt", 64'(cnt_seq[7:0]), 64'h21);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
